// File: rtl/adc_if.sv
// Parallel ADC bus between the driver (master) and the ADC or its emulator (slave).
`timescale 1ns/1ps
interface adc_if;
  logic        convst_A, convst_B, convst_C, convst_D;
  logic        CS, read, STBY, ADCrst;
  logic        Busy;
  logic [15:0] db_out;
  logic        db_oe, conv_overrun, read_err;

  modport master (
    output convst_A, convst_B, convst_C, convst_D, CS, read, STBY, ADCrst,
    input  Busy, db_out, db_oe, conv_overrun, read_err
  );

  modport slave (
    input  convst_A, convst_B, convst_C, convst_D, CS, read, STBY, ADCrst,
    output Busy, db_out, db_oe, conv_overrun, read_err
  );
endinterface

// File: rtl/adc_emulator.sv
// Stand-in for the parallel ADC: timed Busy per conversion, then eight
// deterministic samples {channel, frame} returned on successive read strobes.
`timescale 1ns/1ps
module adc_emulator #(
  parameter int CONV_CYCLES = 4,
  parameter int NUM_CH      = 8
) (
  input logic  clk,
  input logic  rst,
  adc_if.slave bus
);
  localparam int CW = (CONV_CYCLES > 1) ? $clog2(CONV_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, CONV, READY} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] busy_cnt_q, busy_cnt_d;
  logic [3:0]    ptr_q, ptr_d;
  logic [12:0]   frame_q, frame_d, frame_cnt_q, frame_cnt_d;
  logic          conv_q, read_q, rd_act_q;
  logic [15:0]   db_out_q, db_out_d;
  logic          db_oe_q, db_oe_d, ovr_q, ovr_d, rerr_q, rerr_d;

  logic srst, conv_all, start_edge, rd_act, rd_rise, rd_ok, ptr_step;

  assign srst       = rst | bus.ADCrst;
  assign conv_all   = bus.convst_A & bus.convst_B & bus.convst_C & bus.convst_D;
  assign start_edge = conv_all & ~conv_q;
  assign rd_act     = ~bus.CS & ~bus.read;
  assign rd_rise    = rd_act & ~rd_act_q;
  // Standby makes a READY frame look like IDLE to the reader.
  assign rd_ok      = (state_q == READY) && bus.STBY && (ptr_q < 4'(NUM_CH));
  assign ptr_step   = (state_q == READY) && bus.STBY && ~bus.CS && bus.read && ~read_q;

  always_ff @(posedge clk) begin
    if (srst) begin
      state_q     <= IDLE;
      busy_cnt_q  <= '0;
      ptr_q       <= '0;
      frame_q     <= '0;
      frame_cnt_q <= '0;
      conv_q      <= 1'b1;
      read_q      <= 1'b1;
      rd_act_q    <= 1'b0;
      db_out_q    <= '0;
      db_oe_q     <= 1'b0;
      ovr_q       <= 1'b0;
      rerr_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      busy_cnt_q  <= busy_cnt_d;
      ptr_q       <= ptr_d;
      frame_q     <= frame_d;
      frame_cnt_q <= frame_cnt_d;
      conv_q      <= conv_all;
      read_q      <= bus.read;
      rd_act_q    <= rd_act;
      db_out_q    <= db_out_d;
      db_oe_q     <= db_oe_d;
      ovr_q       <= ovr_d;
      rerr_q      <= rerr_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    busy_cnt_d  = busy_cnt_q;
    ptr_d       = ptr_q;
    frame_d     = frame_q;
    frame_cnt_d = frame_cnt_q;
    case (state_q)
      IDLE, READY: begin
        // A start edge outranks a pointer step in the same cycle.
        if (start_edge && bus.STBY) begin
          state_d    = CONV;
          busy_cnt_d = CW'(CONV_CYCLES - 1);
          ptr_d      = '0;
        end else if (ptr_step && ptr_q < 4'(NUM_CH)) begin
          ptr_d = ptr_q + 4'd1;
        end
      end
      CONV: begin
        if (!bus.STBY) begin
          state_d = IDLE;
        end else if (busy_cnt_q == '0) begin
          state_d     = READY;
          frame_d     = frame_cnt_q;
          frame_cnt_d = frame_cnt_q + 13'd1;
        end else begin
          busy_cnt_d = busy_cnt_q - CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ovr_d    = (state_q == CONV) && bus.STBY && start_edge;
    db_oe_d  = rd_act;
    db_out_d = (rd_act && rd_ok) ? {ptr_q[2:0], frame_q} : 16'h0000;
    rerr_d   = rd_rise && !rd_ok;
  end

  assign bus.Busy         = (state_q == CONV);
  assign bus.db_out       = db_out_q;
  assign bus.db_oe        = db_oe_q;
  assign bus.conv_overrun = ovr_q;
  assign bus.read_err     = rerr_q;
endmodule

// File: tb/tb_adc_emulator.sv
// Directed plus randomized checks of adc_emulator against a frame/pointer model.
`timescale 1ns/1ps
module tb_adc_emulator;
  localparam int CONV = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  adc_if bus();
  adc_emulator #(.CONV_CYCLES(CONV), .NUM_CH(8)) dut (.clk(clk), .rst(rst), .bus(bus));

  int checks = 0;
  int errors = 0;

  // Reference model: is a frame available, next channel, frame number latched, conversions done.
  bit m_ready = 0;
  int m_ptr   = 0;
  int m_frame = 0;
  int m_cnt   = 0;

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input int unsigned obs, input int unsigned exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_conv(input logic v);
    bus.convst_A = v; bus.convst_B = v; bus.convst_C = v; bus.convst_D = v;
  endtask

  task automatic conv_full();
    set_conv(1'b0);
    step();
    set_conv(1'b1);
    for (int i = 0; i < CONV; i++) begin
      step();
      chk("busy_hi", bus.Busy, 1);
      chk("no_ovr", bus.conv_overrun, 0);
    end
    step();
    chk("busy_lo", bus.Busy, 0);
    m_ready = 1; m_ptr = 0; m_frame = m_cnt; m_cnt = (m_cnt + 1) % 8192;
  endtask

  task automatic strobe(input int low_cycles);
    int unsigned exp_d;
    int unsigned exp_e;
    if (m_ready && m_ptr < 8) begin
      exp_d = (m_ptr * 8192) + m_frame;
      exp_e = 0;
    end else begin
      exp_d = 0;
      exp_e = 1;
    end
    bus.CS = 1'b0; bus.read = 1'b0;
    step();
    chk("rd_oe", bus.db_oe, 1);
    chk("rd_data", bus.db_out, exp_d);
    chk("rd_err", bus.read_err, exp_e);
    for (int i = 1; i < low_cycles; i++) begin
      step();
      chk("rd_hold", bus.db_out, exp_d);
      chk("rd_err_once", bus.read_err, 0);
    end
    bus.read = 1'b1;
    step();
    chk("rd_oe_off", bus.db_oe, 0);
    if (m_ready && m_ptr < 8) m_ptr++;
    bus.CS = 1'b1;
    step();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    set_conv(1'b0);
    bus.CS = 1'b1; bus.read = 1'b1; bus.STBY = 1'b1; bus.ADCrst = 1'b0;
    step(2);
    chk("rst_busy", bus.Busy, 0);
    chk("rst_oe", bus.db_oe, 0);
    chk("rst_data", bus.db_out, 0);
    chk("rst_ovr", bus.conv_overrun, 0);
    chk("rst_err", bus.read_err, 0);
    rst = 1'b0;
    step(6);

    // First conversion and a full frame, then a ninth read past the end.
    conv_full();
    for (int i = 0; i < 9; i++) strobe(2);

    conv_full();
    for (int i = 0; i < 8; i++) strobe(2);

    // Overlapping start mid-conversion.
    set_conv(1'b0); step(); set_conv(1'b1);
    step(); chk("ovr_b1", bus.Busy, 1); chk("ovr_none", bus.conv_overrun, 0);
    set_conv(1'b0);
    step(); chk("ovr_b2", bus.Busy, 1);
    set_conv(1'b1);
    step(); chk("ovr_pulse", bus.conv_overrun, 1); chk("ovr_b3", bus.Busy, 1);
    step(); chk("ovr_clr", bus.conv_overrun, 0); chk("ovr_b4", bus.Busy, 1);
    step(); chk("ovr_sched", bus.Busy, 0);
    m_ready = 1; m_ptr = 0; m_frame = m_cnt; m_cnt = (m_cnt + 1) % 8192;

    // Read while busy.
    set_conv(1'b0); step(); set_conv(1'b1);
    step(); chk("rb_b1", bus.Busy, 1);
    bus.CS = 1'b0; bus.read = 1'b0;
    step(); chk("rb_oe", bus.db_oe, 1); chk("rb_data", bus.db_out, 0); chk("rb_err", bus.read_err, 1);
    step(); chk("rb_err_once", bus.read_err, 0);
    bus.read = 1'b1;
    step(); chk("rb_b4", bus.Busy, 1);
    bus.CS = 1'b1;
    step(); chk("rb_done", bus.Busy, 0);
    m_ready = 1; m_ptr = 0; m_frame = m_cnt; m_cnt = (m_cnt + 1) % 8192;
    strobe(2);

    // Standby abort, then standby blocking a start.
    set_conv(1'b0); step(); set_conv(1'b1);
    step(); chk("sb_b1", bus.Busy, 1);
    bus.STBY = 1'b0;
    step(); chk("sb_abort", bus.Busy, 0);
    step(); chk("sb_idle", bus.Busy, 0);
    m_ready = 0;
    bus.STBY = 1'b1;
    strobe(2);
    bus.STBY = 1'b0;
    set_conv(1'b0); step(); set_conv(1'b1);
    step(); chk("sb_ign", bus.Busy, 0);
    step(); chk("sb_ign2", bus.Busy, 0);
    bus.STBY = 1'b1;
    step(); chk("sb_noedge", bus.Busy, 0);
    conv_full();
    strobe(3);

    // Randomized frames, partial reads and idle chip-select windows.
    for (int it = 0; it < 20; it++) begin
      conv_full();
      for (int r = $urandom_range(0, 10); r > 0; r--) begin
        step($urandom_range(0, 3));
        if ($urandom_range(0, 3) == 0) begin
          bus.CS = 1'b0;
          step($urandom_range(1, 3));
          chk("cs_only_oe", bus.db_oe, 0);
          bus.CS = 1'b1;
        end
        strobe($urandom_range(2, 4));
      end
    end

    // Run conversions up to the frame counter wrap.
    set_conv(1'b0); step();
    while (m_cnt != 8191) begin
      set_conv(1'b1); step();
      set_conv(1'b0); step(4);
      m_cnt = m_cnt + 1;
    end
    chk("wrap_idle", bus.Busy, 0);
    conv_full();
    for (int i = 0; i < 8; i++) strobe(2);
    conv_full();
    strobe(2); strobe(2);

    // ADC reset after a partial frame, convst held high throughout.
    conv_full();
    for (int i = 0; i < 3; i++) strobe(2);
    bus.ADCrst = 1'b1;
    step();
    chk("ar_busy", bus.Busy, 0);
    chk("ar_oe", bus.db_oe, 0);
    chk("ar_data", bus.db_out, 0);
    chk("ar_ovr", bus.conv_overrun, 0);
    chk("ar_err", bus.read_err, 0);
    bus.ADCrst = 1'b0;
    m_ready = 0; m_ptr = 0; m_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("ar_nostart", bus.Busy, 0);
    end
    bus.CS = 1'b0; bus.read = 1'b0;
    step(); chk("ar_rd_oe", bus.db_oe, 1); chk("ar_rd_data", bus.db_out, 0); chk("ar_rd_err", bus.read_err, 1);
    step();
    bus.CS = 1'b1;
    step(); chk("cs_release", bus.db_oe, 0);
    bus.read = 1'b1;
    step();
    conv_full();
    strobe(2); strobe(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
